// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back stage shared types and constants
package wb_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int DEFAULT_LOAD_TIMEOUT = 16;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load byte/half select, sign/zero extension and misalignment detect
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (addr)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  assign sel_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU: data = {24'h0, sel_byte};
      F3_LH: begin
        data       = {{16{sel_half[15]}}, sel_half};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {16'h0, sel_half};
        misaligned = addr[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipeline write-back stage with variable-latency load wait
// Optional WB->ID forwarding ports are built when WB_FWD_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = DEFAULT_LOAD_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VALID_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemRead_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  input  logic [31:0] ALU_DATA_MEM,
  input  logic [4:0]  RD_MEM,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_RVALID,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB,
  output logic        STALL_WB,
  output logic        LOAD_ERR
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic [31:0] REG_DATA1_ID,
  input  logic [31:0] REG_DATA2_ID,
  output logic [31:0] FWD_DATA1_ID,
  output logic [31:0] FWD_DATA2_ID
`endif
);

  localparam int CW = $clog2(LOAD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  wb_state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [4:0]    ld_rd;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic          ld_we;

  logic [31:0]   ext_data;
  logic          ext_mis;

  logic          wr_fire;
  logic          wr_we;
  logic [31:0]   wr_data;
  logic [4:0]    wr_rd;
  logic          ld_capture;
  logic          err_set;

  // Load/non-load choice is driven by MemRead; MemtoReg carries no extra information here.
  logic          unused_memtoreg;
  assign unused_memtoreg = MemtoReg_MEM;

  load_ext u_load_ext (
    .word       (DMEM_RDATA),
    .addr       (ld_off),
    .funct3     (ld_f3),
    .data       (ext_data),
    .misaligned (ext_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    wr_we      = 1'b0;
    wr_data    = ALU_DATA_MEM;
    wr_rd      = RD_MEM;
    ld_capture = 1'b0;
    err_set    = 1'b0;
    case (state)
      RUN: begin
        if (VALID_MEM) begin
          if (MemRead_MEM) begin
            ld_capture = 1'b1;
            state_next = WAIT_LOAD;
          end else begin
            wr_fire = 1'b1;
            wr_we   = RegWrite_MEM && (RD_MEM != 5'd0);
          end
        end
      end
      WAIT_LOAD: begin
        // A response arriving on the timeout cycle still completes the load.
        if (DMEM_RVALID) begin
          state_next = RUN;
          if (ext_mis) begin
            err_set = 1'b1;
          end else begin
            wr_fire = 1'b1;
            wr_we   = ld_we && (ld_rd != 5'd0);
            wr_data = ext_data;
            wr_rd   = ld_rd;
          end
        end else if (cnt == CNT_LAST) begin
          state_next = RUN;
          err_set    = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      ld_rd       <= 5'd0;
      ld_f3       <= 3'd0;
      ld_off      <= 2'd0;
      ld_we       <= 1'b0;
      RegWrite_WB <= 1'b0;
      ALU_DATA_WB <= 32'h0;
      RD_WB       <= 5'd0;
      LOAD_ERR    <= 1'b0;
    end else begin
      RegWrite_WB <= wr_we;
      if (wr_fire) begin
        ALU_DATA_WB <= wr_data;
        RD_WB       <= wr_rd;
      end
      if (err_set) begin
        LOAD_ERR <= 1'b1;
      end
      if (ld_capture) begin
        ld_rd  <= RD_MEM;
        ld_f3  <= FUNCT3_MEM;
        ld_off <= ALU_DATA_MEM[1:0];
        ld_we  <= RegWrite_MEM;
      end
      if ((state == WAIT_LOAD) && (state_next == WAIT_LOAD)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign STALL_WB = (state == WAIT_LOAD);

`ifdef WB_FWD_EN
  logic wb_live;
  assign wb_live      = RegWrite_WB && (RD_WB != 5'd0);
  assign FWD_DATA1_ID = (wb_live && (RD_WB == RS1_ID)) ? ALU_DATA_WB : REG_DATA1_ID;
  assign FWD_DATA2_ID = (wb_live && (RD_WB == RS2_ID)) ? ALU_DATA_WB : REG_DATA2_ID;
`endif

endmodule
